// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and I-mem.
// Level-held request; response strobe and data are valid only while req is high.
interface fetch_stage_if #(
    parameter int XLEN  = 32,
    parameter int IBITS = 32
);
    logic             req;
    logic [XLEN-1:0]  addr;
    logic             ready;
    logic [IBITS-1:0] data;

    modport master (output req, output addr, input ready, input data);
    modport slave  (input req, input addr, output ready, output data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, level-held I-mem handshake, one-entry skid
// buffer for downstream stalls, and redirects that may land mid-request.
//
// state | meaning
// BUSY  | request at req_addr outstanding (or about to issue after reset)
// SKID  | response parked in skid slot, request held low until stall releases
// DRAIN | old request still in flight after a redirect; its data is dropped
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              IBITS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    fetch_stage_if.master    mem,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [IBITS-1:0] out_instr
);
    typedef enum logic [1:0] {BUSY = 2'd0, SKID = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state, state_nx;
    logic             run;
    logic [XLEN-1:0]  pc, pc_nx, req_addr, req_addr_nx;
    logic [XLEN-1:0]  skid_pc, skid_pc_nx, out_pc_nx;
    logic [IBITS-1:0] skid_instr, skid_instr_nx, out_instr_nx;
    logic             out_valid_nx;
    logic [XLEN-1:0]  target, pc_inc;

    assign target = redirect_pc & ~XLEN'(3);
    assign pc_inc = pc + XLEN'(4);

    // run gates the first request to the cycle after reset is released
    assign mem.req  = run && (state != SKID);
    assign mem.addr = req_addr;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        req_addr_nx   = req_addr;
        out_valid_nx  = out_valid;
        out_pc_nx     = out_pc;
        out_instr_nx  = out_instr;
        skid_pc_nx    = skid_pc;
        skid_instr_nx = skid_instr;
        if (out_valid && !stall_in) out_valid_nx = 1'b0;
        case (state)
            BUSY: begin
                if (!run) begin
                    if (redirect_valid) begin
                        pc_nx        = target;
                        req_addr_nx  = target;
                        out_valid_nx = 1'b0;
                    end
                end else if (redirect_valid) begin
                    out_valid_nx = 1'b0;
                    pc_nx        = target;
                    if (mem.ready) req_addr_nx = target;
                    else           state_nx    = DRAIN;
                end else if (mem.ready) begin
                    pc_nx       = pc_inc;
                    req_addr_nx = pc_inc;
                    if (!out_valid || !stall_in) begin
                        out_valid_nx = 1'b1;
                        out_pc_nx    = req_addr;
                        out_instr_nx = mem.data;
                    end else begin
                        skid_pc_nx    = req_addr;
                        skid_instr_nx = mem.data;
                        state_nx      = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect_valid) begin
                    out_valid_nx = 1'b0;
                    pc_nx        = target;
                    req_addr_nx  = target;
                    state_nx     = BUSY;
                end else if (!stall_in) begin
                    out_valid_nx = 1'b1;
                    out_pc_nx    = skid_pc;
                    out_instr_nx = skid_instr;
                    state_nx     = BUSY;
                end
            end
            DRAIN: begin
                out_valid_nx = 1'b0;
                if (redirect_valid) pc_nx = target;
                if (mem.ready) begin
                    req_addr_nx = redirect_valid ? target : pc;
                    state_nx    = BUSY;
                end
            end
            default: state_nx = BUSY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BUSY;
            run        <= 1'b0;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state      <= state_nx;
            run        <= 1'b1;
            pc         <= pc_nx;
            req_addr   <= req_addr_nx;
            out_valid  <= out_valid_nx;
            out_pc     <= out_pc_nx;
            out_instr  <= out_instr_nx;
            skid_pc    <= skid_pc_nx;
            skid_instr <= skid_instr_nx;
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage. Holds the program counter and runs a level-held request/response handshake to instruction memory. Presents `{out_valid, out_pc, out_instr}` as the D-input of the IF/ID pipeline register, whose enable is `!stall_in`. Absorbs downstream stalls with a one-entry skid buffer and handles branch/exception redirects, including redirects that arrive while a memory request is still in flight.

## Interface
- `XLEN`, 32: address and PC width.
- `IBITS`, 32: instruction width.
- `RESET_PC`, 32'h0000_1000: first fetch address after reset.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `stall_in`  in  1: downstream stall; IF/ID does not load this cycle.
- `redirect_valid`  in  1: redirect request from the execute stage (branch taken or exception).
- `redirect_pc`  in  XLEN: redirect target. Bits [1:0] are forced to 0.
- `mem_req`  out  1: instruction memory request, level-held.
- `mem_addr`  out  XLEN: request address. Stable while `mem_req`=1.
- `mem_ready`  in  1: response strobe, valid only when `mem_req`=1.
- `mem_data`  in  IBITS: response instruction, valid with `mem_ready`.
- `out_valid`  out  1: `out_pc`/`out_instr` hold a real instruction.
- `out_pc`  out  XLEN: PC of the presented instruction.
- `out_instr`  out  IBITS: presented instruction.

## Operation
- **Registers:** `pc` (next fetch), `req_addr` (drives `mem_addr`), output slot (`out_valid`, `out_pc`, `out_instr`), skid slot (`skid_pc`, `skid_instr`), and a 2-bit state.
- **Consume event:** `out_valid`=1 and `stall_in`=0 at a rising edge. If nothing refills the slot on that edge, `out_valid` drops to 0.
- **Memory rule:** once `mem_req` rises, `mem_req` and `mem_addr` stay constant until the edge where `mem_ready`=1. Requests are never aborted.
- **State BUSY** (`mem_req`=1, `mem_addr`=`req_addr`=`pc`):
  - `mem_ready` with no redirect: `pc`+=4, and the next request issues at the new `pc` with no idle cycle.
    - If the slot is free or consumed this edge, the response goes to the output slot and state stays BUSY.
    - Otherwise the response goes to the skid slot and state moves to SKID.
  - `redirect_valid` with `mem_ready` on the same edge: data is discarded, `pc`=`req_addr`=target, `out_valid`=0, state stays BUSY.
  - `redirect_valid` without `mem_ready`: `pc`=target, `out_valid`=0, state moves to DRAIN. `req_addr` keeps the old address.
- **State SKID** (`mem_req`=0):
  - `stall_in`=0: the output slot loads from the skid slot and state returns to BUSY.
  - `redirect_valid`: the skid is dropped, `out_valid`=0, `pc`=target, state returns to BUSY.
- **State DRAIN** (`mem_req`=1, `mem_addr`=old `req_addr`, `out_valid` forced 0):
  - `mem_ready`: data is discarded, `req_addr`=`pc`, state moves to BUSY.
  - A further `redirect_valid`: `pc` is overwritten with the newest target, state stays DRAIN.
  - If both occur on the same edge, the newest target is used.
- **Priority:** redirect > stall. A redirect clears `out_valid` even when `stall_in`=1.
- **Arithmetic:** `pc`+4 is modulo 2^XLEN. `32'hFFFF_FFFC` wraps to 0 with no flag.

## Timing
- **Reset values:** state=BUSY, `pc`=`req_addr`=`RESET_PC`, `out_valid`=0, `out_pc`=0, `out_instr`=0, skid=0.
- **`mem_req` during reset:** `mem_req`=0 while `reset`=1. It is 1 at the first rising edge after reset deasserts.
- **Reset mid-operation:** returns to the reset state immediately, regardless of any outstanding request. The memory side must also be reset.
- **Output latency:** with zero-wait memory (`mem_ready` tied high), one instruction per cycle, and `out_valid` is set on the edge where `mem_ready`=1. The first instruction after reset is visible one edge after the first request edge.
- **Redirect latency:** with the request unstarted or completing this edge, the target request issues the cycle after `redirect_valid`. With a pending request, the target issues the cycle after the drain response.
- **Stall throughput:** each stall cycle with the slot full keeps outputs stable. At most one response is buffered. SKID holds `mem_req` low until the stall releases.
- **Combinational paths:** `mem_req` and `mem_addr` are decoded from registers only. There is no combinational path from `stall_in` or `redirect_valid` to any output.

## Test plan
- **Straight-line, zero-wait:** reset, then `mem_ready`=1 constant, `mem_data`=addr. Expect `out_pc` = 0x1000, 0x1004, 0x1008 on consecutive cycles with `out_valid`=1, and `out_instr`=`out_pc`.
- **Wait states:** `mem_ready` asserted every 3rd cycle. Expect `mem_addr` stable across the waits, `out_valid` high for one cycle per response, and PCs increasing by 4.
- **Stall into skid:** slot full, `stall_in`=1 for 4 cycles while a response arrives. Expect `mem_req`=0 during SKID, outputs unchanged, and on release the skid instruction (0x1008) appears next with no loss or duplication.
- **Redirect during pending request:** request to 0x1004 waiting, `redirect_valid` with 0x2002. Expect `mem_addr` to stay 0x1004 until `mem_ready`, that data discarded, the next request at 0x2000, and `out_valid`=0 meanwhile.
- **Redirect and `mem_ready` on the same edge, plus double redirect in DRAIN:** expect the discard, then fetch of the latest target only (0x3000 after 0x2000 then 0x3000).
- **Wrap and reset:** `redirect_pc`=0xFFFF_FFFC, then the next fetch is at 0. Assert `reset` mid-DRAIN: expect `out_valid`=0 and `mem_req`=0 immediately, and a restart at 0x1000.
